urv_csr_mbx: RTL and testbench

Parametrised CSR unit for the uRV execute stage. It provides NUM_SCRATCH debug scratch registers, counters of configurable width, and inbound/outbound debug mailboxes implemented as MBX_DEPTH-entry FIFOs with status, overflow and underflow reporting. It sits beside the ALU and is fed by decode-stage CSR fields. The read value and the computed write value are presented in the same cycle as the instruction.

---
 rtl/urv_csr_mbx.sv | 265 ++++++++++++++++++++++++++
 tb/tb_urv_csr_mbx.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/urv_csr_mbx.sv
// uRV execute-stage CSR unit: debug scratch registers, mscratch, counter
// read-out and a pair of debug mailboxes (inbound / outbound FIFOs) with
// sticky overflow / underflow status.
//
// Handshake summary:
//   inbound : the debugger offers dbg_mbxi_data_i with dbg_mbxi_valid_i. The
//             word is taken on any clock edge where the FIFO is not full,
//             or where the CPU pops MBXI in that same cycle. The
//             dbg_mbxi_ready_o output shows "not full" only, so a push
//             that lines up with a CPU pop is accepted even while ready_o=0.
//             A word offered when it cannot be taken is dropped and
//             mbxi_ovf is set.
//   outbound: dbg_mbxo_valid_o means "head word present". A pulse on
//             dbg_mbxo_read_i pops that head on the clock edge. It is
//             ignored while valid_o is low.
module urv_csr_mbx #(
    parameter int unsigned NUM_SCRATCH = 4,
    parameter int unsigned MBX_DEPTH   = 8,
    parameter int unsigned CNT_WIDTH   = 40,
    parameter logic [11:0] DBG_BASE    = 12'h7C0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 x_stall_i,
    input  logic                 x_kill_i,
    input  logic                 d_is_csr_i,
    input  logic [2:0]           d_fun_i,
    input  logic [4:0]           d_csr_imm_i,
    input  logic [11:0]          d_csr_sel_i,
    input  logic [31:0]          d_rs1_i,
    output logic [31:0]          x_rd_o,
    output logic [31:0]          x_csr_write_value_o,
    input  logic [CNT_WIDTH-1:0] csr_time_i,
    input  logic [CNT_WIDTH-1:0] csr_cycles_i,
    input  logic [31:0]          csr_mstatus_i,
    input  logic [31:0]          csr_mip_i,
    input  logic [31:0]          csr_mie_i,
    input  logic [31:0]          csr_mepc_i,
    input  logic [31:0]          csr_mcause_i,
    output logic [31:0]          csr_mscratch_o,
    input  logic [31:0]          dbg_mbxi_data_i,
    input  logic                 dbg_mbxi_valid_i,
    output logic                 dbg_mbxi_ready_o,
    output logic [31:0]          dbg_mbxo_data_o,
    output logic                 dbg_mbxo_valid_o,
    input  logic                 dbg_mbxo_read_i,
    output logic                 mbx_irq_o
);

    localparam int unsigned PTR_W = $clog2(MBX_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [11:0] ADDR_CYCLES_LO = 12'hC00;
    localparam logic [11:0] ADDR_CYCLES_HI = 12'hC80;
    localparam logic [11:0] ADDR_TIME_LO   = 12'hC01;
    localparam logic [11:0] ADDR_TIME_HI   = 12'hC81;
    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MIP       = 12'h344;
    localparam logic [11:0] ADDR_MBXO      = DBG_BASE + 12'd16;
    localparam logic [11:0] ADDR_MBXI      = DBG_BASE + 12'd17;
    localparam logic [11:0] ADDR_MBXSTAT   = DBG_BASE + 12'd18;

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    logic [31:0]      scratch_q [NUM_SCRATCH];
    logic [31:0]      scratch_d [NUM_SCRATCH];
    logic [31:0]      mscratch_q, mscratch_d;

    logic [31:0]      in_mem_q  [MBX_DEPTH];
    logic [PTR_W-1:0] in_wr_ptr_q, in_wr_ptr_d;
    logic [PTR_W-1:0] in_rd_ptr_q, in_rd_ptr_d;
    logic [CNT_W-1:0] in_cnt_q, in_cnt_d;

    logic [31:0]      out_mem_q [MBX_DEPTH];
    logic [PTR_W-1:0] out_wr_ptr_q, out_wr_ptr_d;
    logic [PTR_W-1:0] out_rd_ptr_q, out_rd_ptr_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;

    // flags: [0] mbxi_ovf, [1] mbxo_ovf, [2] mbxi_udf
    logic [2:0]       flags_q, flags_d;

    // ---------------------------------------------------------------
    // Operand / operation decode
    // ---------------------------------------------------------------
    logic [31:0] csr_in1;
    logic [31:0] csr_in2;
    logic [31:0] csr_out;
    logic [1:0]  csr_op;
    logic        write_intent;
    logic        commit;
    logic [63:0] cycles_ext;
    logic [63:0] time_ext;

    assign csr_op     = d_fun_i[1:0];
    assign csr_in2    = d_fun_i[2] ? {27'b0, d_csr_imm_i} : d_rs1_i;
    assign commit     = d_is_csr_i & ~x_stall_i & ~x_kill_i;
    assign cycles_ext = 64'(csr_cycles_i);
    assign time_ext   = 64'(csr_time_i);

    // Set/clear ops with a zero mask are pure reads and must not write.
    assign write_intent = (csr_op == 2'b01) ||
                          (((csr_op == 2'b10) || (csr_op == 2'b11)) && (csr_in2 != 32'h0));

    // Compute the value a write would store (RW / RS / RC)
    always_comb begin
        csr_out = csr_in1;
        case (csr_op)
            2'b01:   csr_out = csr_in2;
            2'b10:   csr_out = csr_in1 | csr_in2;
            2'b11:   csr_out = csr_in1 & ~csr_in2;
            default: csr_out = csr_in1;
        endcase
    end

    // ---------------------------------------------------------------
    // FIFO status and request decode
    // ---------------------------------------------------------------
    logic        in_full, in_empty, out_full, out_empty;
    logic        in_pop_req, in_pop, in_push, in_ovf_set, in_udf_set;
    logic        out_push_req, out_push, out_pop, out_ovf_set;
    logic        stat_wr;
    logic [31:0] mbxi_head;
    logic [31:0] mbxstat;

    assign in_full   = (in_cnt_q == CNT_W'(MBX_DEPTH));
    assign in_empty  = (in_cnt_q == '0);
    assign out_full  = (out_cnt_q == CNT_W'(MBX_DEPTH));
    assign out_empty = (out_cnt_q == '0);

    // Any committed MBXI access pops, even a pure read.
    assign in_pop_req = commit && (d_csr_sel_i == ADDR_MBXI);
    assign in_pop     = in_pop_req && !in_empty;
    assign in_udf_set = in_pop_req && in_empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still take the word.
    assign in_push    = dbg_mbxi_valid_i && (!in_full || in_pop);
    assign in_ovf_set = dbg_mbxi_valid_i && in_full && !in_pop;

    assign out_push_req = commit && write_intent && (d_csr_sel_i == ADDR_MBXO);
    assign out_pop      = dbg_mbxo_read_i && !out_empty;
    assign out_push     = out_push_req && (!out_full || out_pop);
    assign out_ovf_set  = out_push_req && out_full && !out_pop;

    assign stat_wr = commit && write_intent && (d_csr_sel_i == ADDR_MBXSTAT);

    assign mbxi_head = in_empty ? 32'h0 : in_mem_q[in_rd_ptr_q];
    assign mbxstat   = {13'b0, flags_q, 8'(out_cnt_q), 8'(in_cnt_q)};

    // CSR read multiplexer; anything not decoded reads as zero
    always_comb begin
        csr_in1 = 32'h0;
        case (d_csr_sel_i)
            ADDR_CYCLES_LO: csr_in1 = cycles_ext[31:0];
            ADDR_CYCLES_HI: csr_in1 = cycles_ext[63:32];
            ADDR_TIME_LO:   csr_in1 = time_ext[31:0];
            ADDR_TIME_HI:   csr_in1 = time_ext[63:32];
            ADDR_MSTATUS:   csr_in1 = csr_mstatus_i;
            ADDR_MIE:       csr_in1 = csr_mie_i;
            ADDR_MSCRATCH:  csr_in1 = mscratch_q;
            ADDR_MEPC:      csr_in1 = csr_mepc_i;
            ADDR_MCAUSE:    csr_in1 = csr_mcause_i;
            ADDR_MIP:       csr_in1 = csr_mip_i;
            ADDR_MBXI:      csr_in1 = mbxi_head;
            ADDR_MBXO:      csr_in1 = 32'h0;
            ADDR_MBXSTAT:   csr_in1 = mbxstat;
            default:        csr_in1 = 32'h0;
        endcase
        for (int i = 0; i < int'(NUM_SCRATCH); i++) begin
            if (d_csr_sel_i == DBG_BASE + 12'(i)) begin
                csr_in1 = scratch_q[i];
            end
        end
    end

    // Next state for scratch registers and mscratch
    always_comb begin
        mscratch_d = mscratch_q;
        if (commit && write_intent && (d_csr_sel_i == ADDR_MSCRATCH)) begin
            mscratch_d = csr_out;
        end
        for (int i = 0; i < int'(NUM_SCRATCH); i++) begin
            scratch_d[i] = scratch_q[i];
            if (commit && write_intent && (d_csr_sel_i == DBG_BASE + 12'(i))) begin
                scratch_d[i] = csr_out;
            end
        end
    end

    // Next state for pointers and occupancy counts of both FIFOs
    always_comb begin
        in_wr_ptr_d  = in_push  ? in_wr_ptr_q  + PTR_W'(1) : in_wr_ptr_q;
        in_rd_ptr_d  = in_pop   ? in_rd_ptr_q  + PTR_W'(1) : in_rd_ptr_q;
        out_wr_ptr_d = out_push ? out_wr_ptr_q + PTR_W'(1) : out_wr_ptr_q;
        out_rd_ptr_d = out_pop  ? out_rd_ptr_q + PTR_W'(1) : out_rd_ptr_q;

        in_cnt_d = in_cnt_q;
        if (in_push && !in_pop) begin
            in_cnt_d = in_cnt_q + CNT_W'(1);
        end else if (in_pop && !in_push) begin
            in_cnt_d = in_cnt_q - CNT_W'(1);
        end

        out_cnt_d = out_cnt_q;
        if (out_push && !out_pop) begin
            out_cnt_d = out_cnt_q + CNT_W'(1);
        end else if (out_pop && !out_push) begin
            out_cnt_d = out_cnt_q - CNT_W'(1);
        end
    end

    // Sticky flags: a write clears where csr_out has ones, new events win
    always_comb begin
        logic [2:0] clr;
        clr     = stat_wr ? csr_out[18:16] : 3'b000;
        flags_d = (flags_q & ~clr) | {in_udf_set, out_ovf_set, in_ovf_set};
    end

    // Register update with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scratch_q    <= '{default: '0};
            mscratch_q   <= '0;
            in_wr_ptr_q  <= '0;
            in_rd_ptr_q  <= '0;
            in_cnt_q     <= '0;
            out_wr_ptr_q <= '0;
            out_rd_ptr_q <= '0;
            out_cnt_q    <= '0;
            flags_q      <= '0;
        end else begin
            scratch_q    <= scratch_d;
            mscratch_q   <= mscratch_d;
            in_wr_ptr_q  <= in_wr_ptr_d;
            in_rd_ptr_q  <= in_rd_ptr_d;
            in_cnt_q     <= in_cnt_d;
            out_wr_ptr_q <= out_wr_ptr_d;
            out_rd_ptr_q <= out_rd_ptr_d;
            out_cnt_q    <= out_cnt_d;
            flags_q      <= flags_d;
        end
    end

    // FIFO storage; contents are meaningless outside the count so no reset
    always_ff @(posedge clk_i) begin
        if (!rst_i && in_push) begin
            in_mem_q[in_wr_ptr_q] <= dbg_mbxi_data_i;
        end
        if (!rst_i && out_push) begin
            out_mem_q[out_wr_ptr_q] <= csr_out;
        end
    end

    assign x_rd_o              = csr_in1;
    assign x_csr_write_value_o = csr_out;
    assign csr_mscratch_o      = mscratch_q;
    assign dbg_mbxi_ready_o    = !in_full;
    assign dbg_mbxo_valid_o    = !out_empty;
    assign dbg_mbxo_data_o     = out_empty ? 32'h0 : out_mem_q[out_rd_ptr_q];
    assign mbx_irq_o           = !in_empty;

endmodule

// File: tb/tb_urv_csr_mbx.sv
// Directed bench for urv_csr_mbx: scratch/mscratch access, counter and
// machine CSR reads, inbound and outbound mailbox behaviour including
// full/empty corner cases, sticky status flags and mid-stream reset.
`timescale 1ns/1ps
module tb_urv_csr_mbx;

  localparam logic [2:0] F_RW  = 3'b001;
  localparam logic [2:0] F_RS  = 3'b010;
  localparam logic [2:0] F_RC  = 3'b011;
  localparam logic [2:0] F_RWI = 3'b101;

  localparam logic [11:0] A_SCR3  = 12'h7C3;
  localparam logic [11:0] A_MBXO  = 12'h7D0;
  localparam logic [11:0] A_MBXI  = 12'h7D1;
  localparam logic [11:0] A_STAT  = 12'h7D2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        x_stall_i, x_kill_i, d_is_csr_i;
  logic [2:0]  d_fun_i;
  logic [4:0]  d_csr_imm_i;
  logic [11:0] d_csr_sel_i;
  logic [31:0] d_rs1_i;
  logic [31:0] x_rd_o, x_csr_write_value_o;
  logic [63:0] csr_time_i, csr_cycles_i;
  logic [31:0] csr_mstatus_i, csr_mip_i, csr_mie_i, csr_mepc_i, csr_mcause_i;
  logic [31:0] csr_mscratch_o;
  logic [31:0] dbg_mbxi_data_i;
  logic        dbg_mbxi_valid_i, dbg_mbxi_ready_o;
  logic [31:0] dbg_mbxo_data_o;
  logic        dbg_mbxo_valid_o, dbg_mbxo_read_i, mbx_irq_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];  // outbound words expected at dbg_mbxo_data_o
  logic [31:0] in_q[$];   // inbound words expected from MBXI reads

  // clock / reset
  always #5 clk_i = ~clk_i;

  urv_csr_mbx #(
    .NUM_SCRATCH(4), .MBX_DEPTH(8), .CNT_WIDTH(64), .DBG_BASE(12'h7C0)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .x_stall_i(x_stall_i), .x_kill_i(x_kill_i),
    .d_is_csr_i(d_is_csr_i), .d_fun_i(d_fun_i), .d_csr_imm_i(d_csr_imm_i),
    .d_csr_sel_i(d_csr_sel_i), .d_rs1_i(d_rs1_i),
    .x_rd_o(x_rd_o), .x_csr_write_value_o(x_csr_write_value_o),
    .csr_time_i(csr_time_i), .csr_cycles_i(csr_cycles_i),
    .csr_mstatus_i(csr_mstatus_i), .csr_mip_i(csr_mip_i), .csr_mie_i(csr_mie_i),
    .csr_mepc_i(csr_mepc_i), .csr_mcause_i(csr_mcause_i),
    .csr_mscratch_o(csr_mscratch_o),
    .dbg_mbxi_data_i(dbg_mbxi_data_i), .dbg_mbxi_valid_i(dbg_mbxi_valid_i),
    .dbg_mbxi_ready_o(dbg_mbxi_ready_o),
    .dbg_mbxo_data_o(dbg_mbxo_data_o), .dbg_mbxo_valid_o(dbg_mbxo_valid_o),
    .dbg_mbxo_read_i(dbg_mbxo_read_i), .mbx_irq_o(mbx_irq_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    d_is_csr_i = 1'b0; x_stall_i = 1'b0; x_kill_i = 1'b0;
    d_fun_i = 3'b0; d_csr_imm_i = 5'b0; d_csr_sel_i = 12'h0; d_rs1_i = 32'h0;
    dbg_mbxi_valid_i = 1'b0; dbg_mbxi_data_i = 32'h0; dbg_mbxo_read_i = 1'b0;
  endtask

  // driver: one CSR instruction in execute for one cycle; any debug-side
  // signals the caller set beforehand are applied in the same cycle
  task automatic csr(input logic [2:0] fun, input logic [11:0] sel, input logic [31:0] rs1,
                     input logic [4:0] imm, input logic stall, input logic kill,
                     output logic [31:0] rd, output logic [31:0] wv);
    d_is_csr_i = 1'b1; d_fun_i = fun; d_csr_sel_i = sel; d_rs1_i = rs1;
    d_csr_imm_i = imm; x_stall_i = stall; x_kill_i = kill;
    #2;
    rd = x_rd_o;
    wv = x_csr_write_value_o;
    @(posedge clk_i); #1;
    clear_inputs();
  endtask

  task automatic rd_csr(input logic [11:0] sel, output logic [31:0] rd);
    logic [31:0] wv;
    csr(F_RS, sel, 32'h0, 5'h0, 1'b0, 1'b0, rd, wv);
  endtask

  task automatic dbg_push(input logic [31:0] data);
    dbg_mbxi_valid_i = 1'b1; dbg_mbxi_data_i = data;
    @(posedge clk_i); #1;
    clear_inputs();
  endtask

  task automatic dbg_pop();
    dbg_mbxo_read_i = 1'b1;
    @(posedge clk_i); #1;
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd, wv;
    clear_inputs();
    csr_time_i = '0; csr_cycles_i = '0;
    csr_mstatus_i = 32'h0000_1888; csr_mie_i = 32'h0000_0888; csr_mip_i = 32'h0000_0080;
    csr_mepc_i = 32'h8000_0100; csr_mcause_i = 32'h8000_000B;

    // reset state
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    check("rst_valid", 32'(dbg_mbxo_valid_o), 32'd0);
    check("rst_ready", 32'(dbg_mbxi_ready_o), 32'd1);
    check("rst_irq", 32'(mbx_irq_o), 32'd0);
    check("rst_mbxo_data", dbg_mbxo_data_o, 32'h0);
    check("rst_mscratch", csr_mscratch_o, 32'h0);
    rd_csr(A_STAT, rd);
    check("rst_mbxstat", rd, 32'h0);

    // scratch 3: write, read, set-with-zero, clear
    csr(F_RW, A_SCR3, 32'hDEADBEEF, 5'h0, 1'b0, 1'b0, rd, wv);
    check("scr3_old", rd, 32'h0);
    check("scr3_wv", wv, 32'hDEADBEEF);
    csr(F_RS, A_SCR3, 32'h0, 5'h0, 1'b0, 1'b0, rd, wv);
    check("scr3_rd", rd, 32'hDEADBEEF);
    csr(F_RC, A_SCR3, 32'h0000FFFF, 5'h0, 1'b0, 1'b0, rd, wv);
    check("scr3_rc_wv", wv, 32'hDEAD0000);
    rd_csr(A_SCR3, rd);
    check("scr3_after_rc", rd, 32'hDEAD0000);

    // mscratch via immediate write
    csr(F_RWI, 12'h340, 32'hFFFF_FFFF, 5'h15, 1'b0, 1'b0, rd, wv);
    check("mscratch_out", csr_mscratch_o, 32'h15);

    // stalled and killed accesses have no side effects
    csr(F_RW, A_SCR3, 32'h1, 5'h0, 1'b1, 1'b0, rd, wv);
    rd_csr(A_SCR3, rd);
    check("stall_scr3", rd, 32'hDEAD0000);
    csr(F_RW, A_MBXO, 32'h55, 5'h0, 1'b0, 1'b1, rd, wv);
    check("kill_mbxo_valid", 32'(dbg_mbxo_valid_o), 32'd0);
    csr(F_RS, A_MBXO, 32'h0, 5'h0, 1'b0, 1'b0, rd, wv);
    check("mbxo_reads_zero", rd, 32'h0);
    check("rs0_mbxo_nopush", 32'(dbg_mbxo_valid_o), 32'd0);

    // inbound: fill to full
    for (int w = 1; w <= 8; w++) begin
      dbg_push(32'(w));
      in_q.push_back(32'(w));
    end
    check("in_full_ready", 32'(dbg_mbxi_ready_o), 32'd0);
    check("in_full_irq", 32'(mbx_irq_o), 32'd1);
    rd_csr(A_STAT, rd);
    check("in_full_stat", rd, 32'h8);

    // stalled MBXI access does not pop
    csr(F_RS, A_MBXI, 32'h0, 5'h0, 1'b1, 1'b0, rd, wv);
    check("stall_mbxi_head", rd, in_q[0]);
    rd_csr(A_STAT, rd);
    check("stall_mbxi_cnt", rd, 32'h8);

    // dropped 9th push in the same cycle as a flag-clear write: set wins
    dbg_mbxi_valid_i = 1'b1; dbg_mbxi_data_i = 32'h99;
    csr(F_RW, A_STAT, 32'h70000, 5'h0, 1'b0, 1'b0, rd, wv);
    rd_csr(A_STAT, rd);
    check("in_ovf_setwins", rd, 32'h10008);
    csr(F_RW, A_STAT, 32'h70000, 5'h0, 1'b0, 1'b0, rd, wv);
    rd_csr(A_STAT, rd);
    check("stat_cleared", rd, 32'h8);

    // full FIFO: debug push together with CPU pop is accepted
    dbg_mbxi_valid_i = 1'b1; dbg_mbxi_data_i = 32'h9;
    csr(F_RS, A_MBXI, 32'h0, 5'h0, 1'b0, 1'b0, rd, wv);
    check("pushpop_head", rd, in_q.pop_front());
    in_q.push_back(32'h9);
    rd_csr(A_STAT, rd);
    check("pushpop_stat", rd, 32'h8);

    // drain inbound in order, then underflow
    for (int k = 0; k < 8; k++) begin
      rd_csr(A_MBXI, rd);
      check("mbxi_drain", rd, in_q.pop_front());
    end
    rd_csr(A_MBXI, rd);
    check("mbxi_empty_rd", rd, 32'h0);
    rd_csr(A_STAT, rd);
    check("mbxi_udf_stat", rd, 32'h40000);
    check("empty_irq", 32'(mbx_irq_o), 32'd0);
    check("empty_ready", 32'(dbg_mbxi_ready_o), 32'd1);

    // underflow pop with simultaneous push: push still accepted
    csr(F_RW, A_STAT, 32'h70000, 5'h0, 1'b0, 1'b0, rd, wv);
    dbg_mbxi_valid_i = 1'b1; dbg_mbxi_data_i = 32'hAA;
    csr(F_RS, A_MBXI, 32'h0, 5'h0, 1'b0, 1'b0, rd, wv);
    check("udf_push_rd", rd, 32'h0);
    in_q.push_back(32'hAA);
    rd_csr(A_STAT, rd);
    check("udf_push_stat", rd, 32'h40001);
    rd_csr(A_MBXI, rd);
    check("udf_push_word", rd, in_q.pop_front());
    csr(F_RW, A_STAT, 32'h70000, 5'h0, 1'b0, 1'b0, rd, wv);

    // outbound: 3 pushes, then push + debug pop in one cycle
    for (int k = 1; k <= 3; k++) begin
      csr(F_RW, A_MBXO, 32'hA0 + 32'(k), 5'h0, 1'b0, 1'b0, rd, wv);
      exp_q.push_back(32'hA0 + 32'(k));
    end
    check("out_valid", 32'(dbg_mbxo_valid_o), 32'd1);
    rd_csr(A_STAT, rd);
    check("out_cnt3", rd, 32'h300);
    check("out_head_pp", dbg_mbxo_data_o, exp_q.pop_front());
    dbg_mbxo_read_i = 1'b1;
    csr(F_RW, A_MBXO, 32'hA4, 5'h0, 1'b0, 1'b0, rd, wv);
    exp_q.push_back(32'hA4);
    rd_csr(A_STAT, rd);
    check("out_cnt_pp", rd, 32'h300);
    while (exp_q.size() > 0) begin
      check("out_drain", dbg_mbxo_data_o, exp_q.pop_front());
      dbg_pop();
    end
    check("out_empty_valid", 32'(dbg_mbxo_valid_o), 32'd0);
    check("out_empty_data", dbg_mbxo_data_o, 32'h0);
    dbg_pop();
    rd_csr(A_STAT, rd);
    check("out_pop_empty", rd, 32'h0);

    // outbound overflow
    for (int k = 0; k < 9; k++) begin
      csr(F_RW, A_MBXO, 32'h100 + 32'(k), 5'h0, 1'b0, 1'b0, rd, wv);
      if (k < 8) exp_q.push_back(32'h100 + 32'(k));
    end
    rd_csr(A_STAT, rd);
    check("out_ovf_stat", rd, 32'h20800);
    check("out_ovf_head", dbg_mbxo_data_o, exp_q[0]);

    // counters and machine CSRs
    csr_cycles_i = 64'h1234_5678_9ABC_DEF0;
    csr_time_i   = 64'h0000_0001_FFFF_FFFF;
    rd_csr(12'hC80, rd); check("cycles_hi", rd, 32'h12345678);
    rd_csr(12'hC00, rd); check("cycles_lo", rd, 32'h9ABCDEF0);
    rd_csr(12'hC81, rd); check("time_hi", rd, 32'h00000001);
    rd_csr(12'hC01, rd); check("time_lo", rd, 32'hFFFFFFFF);
    rd_csr(12'h300, rd); check("mstatus", rd, 32'h00001888);
    rd_csr(12'h304, rd); check("mie", rd, 32'h00000888);
    rd_csr(12'h341, rd); check("mepc", rd, 32'h80000100);
    rd_csr(12'h342, rd); check("mcause", rd, 32'h8000000B);
    rd_csr(12'h344, rd); check("mip", rd, 32'h00000080);
    rd_csr(12'h123, rd); check("unmapped", rd, 32'h0);
    rd_csr(12'h7C4, rd); check("scratch_oob", rd, 32'h0);

    // reset with both mailboxes holding data
    dbg_push(32'h77);
    dbg_push(32'h78);
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    exp_q.delete();
    in_q.delete();
    check("mid_rst_valid", 32'(dbg_mbxo_valid_o), 32'd0);
    check("mid_rst_ready", 32'(dbg_mbxi_ready_o), 32'd1);
    check("mid_rst_irq", 32'(mbx_irq_o), 32'd0);
    check("mid_rst_data", dbg_mbxo_data_o, 32'h0);
    check("mid_rst_mscratch", csr_mscratch_o, 32'h0);
    rd_csr(A_STAT, rd); check("mid_rst_stat", rd, 32'h0);
    rd_csr(A_SCR3, rd); check("mid_rst_scr3", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
